// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
// Sequencing controller for the 5-stage RISC-V pipeline (IF, ID, EX, MEM, WB).
// It generates the PC enable, the per-stage register enables and flushes, and
// the multiply handshake. It resolves, in priority order: taken redirects
// from MEM, multi-cycle multiply occupancy of EX, and load-use hazards.
// It also keeps stall and redirect performance counters.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   enable            start execution (only looked at in IDLE)
//   id_rs1, id_rs2    source register fields of the instruction in IF_ID
//   id_uses_rs2       instruction in ID actually reads rs2
//   idex_mem_read     instruction in ID_EX is a load
//   idex_rd           destination register of the instruction in ID_EX
//   idex_is_mult      instruction in ID_EX is a MUL
//   exmem_take        taken branch or jump sitting in EX_MEM
//   pc_en, *_en       PC and stage register enables
//   *_flush           load a bubble into that register (overrides its enable)
//   mult_start        pulse on the first EX cycle of a multi-cycle MUL
//   mult_busy         a MUL is occupying EX
//   stall_cnt         cycles spent running with the PC frozen
//   flush_cnt         number of taken redirects
module pipeline_hazard_ctrl #(
  parameter int MULT_LAT = 4,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs2,
  input  logic             idex_mem_read,
  input  logic [4:0]       idex_rd,
  input  logic             idex_is_mult,
  input  logic             exmem_take,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             mult_start,
  output logic             mult_busy,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int MW = $clog2(MULT_LAT) + 1;
  localparam bit MULT_MULTI = (MULT_LAT > 1);
  // The entry cycle is the first of the MULT_LAT EX cycles and the release
  // cycle (mcnt==0) is the last, so the count starts at MULT_LAT-2.
  localparam logic [MW-1:0] MCNT_INIT = MULT_MULTI ? MW'(MULT_LAT - 2) : '0;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    MULT_WAIT
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [MW-1:0] mcnt;
  logic [MW-1:0] mcnt_next;
  logic          load_use;
  logic          mult_hit;

  // A load into x0 never creates a dependency; rs2 only matters when read.
  assign load_use = idex_mem_read && (idex_rd != 5'd0) &&
                    ((idex_rd == id_rs1) || (id_uses_rs2 && (idex_rd == id_rs2)));

  // With a single-cycle multiplier a MUL is just an ordinary instruction.
  assign mult_hit = idex_is_mult && MULT_MULTI;

  // State and multiply down-counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      mcnt  <= '0;
    end else begin
      state <= state_next;
      mcnt  <= mcnt_next;
    end
  end

  // Next-state and output decode. During a multiply stall the front end
  // freezes while a bubble drains through EX_MEM and MEM_WB.
  always_comb begin
    state_next   = state;
    mcnt_next    = mcnt;
    pc_en        = 1'b0;
    if_id_en     = 1'b0;
    id_ex_en     = 1'b0;
    ex_mem_en    = 1'b0;
    mem_wb_en    = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    mult_start   = 1'b0;
    mult_busy    = 1'b0;
    case (state)
      IDLE: begin
        if (enable) state_next = RUN;
      end
      RUN: begin
        if (exmem_take) begin
          // Everything younger than the redirect is wrong-path.
          pc_en        = 1'b1;
          if_id_en     = 1'b1;
          id_ex_en     = 1'b1;
          ex_mem_en    = 1'b1;
          mem_wb_en    = 1'b1;
          if_id_flush  = 1'b1;
          id_ex_flush  = 1'b1;
          ex_mem_flush = 1'b1;
        end else if (mult_hit) begin
          ex_mem_en    = 1'b1;
          mem_wb_en    = 1'b1;
          ex_mem_flush = 1'b1;
          mult_start   = 1'b1;
          mult_busy    = 1'b1;
          state_next   = MULT_WAIT;
          mcnt_next    = MCNT_INIT;
        end else if (load_use) begin
          id_ex_en    = 1'b1;
          ex_mem_en   = 1'b1;
          mem_wb_en   = 1'b1;
          id_ex_flush = 1'b1;
        end else begin
          pc_en     = 1'b1;
          if_id_en  = 1'b1;
          id_ex_en  = 1'b1;
          ex_mem_en = 1'b1;
          mem_wb_en = 1'b1;
        end
      end
      MULT_WAIT: begin
        mult_busy = 1'b1;
        if (mcnt != '0) begin
          ex_mem_en    = 1'b1;
          mem_wb_en    = 1'b1;
          ex_mem_flush = 1'b1;
          mcnt_next    = mcnt - 1'b1;
        end else begin
          // Release: the MUL result is captured into EX_MEM on this edge.
          pc_en      = 1'b1;
          if_id_en   = 1'b1;
          id_ex_en   = 1'b1;
          ex_mem_en  = 1'b1;
          mem_wb_en  = 1'b1;
          state_next = RUN;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Performance counters; both wrap naturally at 2^CNT_W.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if ((state != IDLE) && !pc_en) stall_cnt <= stall_cnt + CNT_W'(1);
      if ((state == RUN) && exmem_take) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl
// Self-checking bench for pipeline_hazard_ctrl. One instance uses a 4-cycle
// multiplier, a second shares the same inputs with a single-cycle multiplier.
// Output vectors are packed as
// {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
//  if_id_flush, id_ex_flush, ex_mem_flush, mult_start, mult_busy}.
module tb_pipeline_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [4:0]  id_rs1 = '0;
  logic [4:0]  id_rs2 = '0;
  logic        id_uses_rs2 = 1'b0;
  logic        idex_mem_read = 1'b0;
  logic [4:0]  idex_rd = '0;
  logic        idex_is_mult = 1'b0;
  logic        exmem_take = 1'b0;

  logic        pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic        if_id_flush, id_ex_flush, ex_mem_flush, mult_start, mult_busy;
  logic [31:0] stall_cnt, flush_cnt;

  logic        pc_en_1, if_id_en_1, id_ex_en_1, ex_mem_en_1, mem_wb_en_1;
  logic        if_id_flush_1, id_ex_flush_1, ex_mem_flush_1, mult_start_1, mult_busy_1;
  logic [31:0] stall_cnt_1, flush_cnt_1;

  logic [9:0]  outs;
  logic [9:0]  outs_1;

  int assert_count = 0;
  int fail_count   = 0;

  localparam logic [9:0] OUT_IDLE   = 10'b00000_000_00;
  localparam logic [9:0] OUT_RUN    = 10'b11111_000_00;
  localparam logic [9:0] OUT_LU     = 10'b00111_010_00;
  localparam logic [9:0] OUT_MULT   = 10'b00011_001_11;
  localparam logic [9:0] OUT_REDIR  = 10'b11111_111_00;

  always #5 clk = ~clk;

  assign outs   = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                   if_id_flush, id_ex_flush, ex_mem_flush, mult_start, mult_busy};
  assign outs_1 = {pc_en_1, if_id_en_1, id_ex_en_1, ex_mem_en_1, mem_wb_en_1,
                   if_id_flush_1, id_ex_flush_1, ex_mem_flush_1, mult_start_1, mult_busy_1};

  pipeline_hazard_ctrl #(.MULT_LAT(4), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2),
    .idex_mem_read(idex_mem_read), .idex_rd(idex_rd),
    .idex_is_mult(idex_is_mult), .exmem_take(exmem_take),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
    .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush),
    .mult_start(mult_start), .mult_busy(mult_busy),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipeline_hazard_ctrl #(.MULT_LAT(1), .CNT_W(32)) dut1 (
    .clk(clk), .rst(rst), .enable(enable),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2),
    .idex_mem_read(idex_mem_read), .idex_rd(idex_rd),
    .idex_is_mult(idex_is_mult), .exmem_take(exmem_take),
    .pc_en(pc_en_1), .if_id_en(if_id_en_1), .id_ex_en(id_ex_en_1),
    .ex_mem_en(ex_mem_en_1), .mem_wb_en(mem_wb_en_1),
    .if_id_flush(if_id_flush_1), .id_ex_flush(id_ex_flush_1), .ex_mem_flush(ex_mem_flush_1),
    .mult_start(mult_start_1), .mult_busy(mult_busy_1),
    .stall_cnt(stall_cnt_1), .flush_cnt(flush_cnt_1)
  );

  typedef struct {
    string      name;
    logic       take;
    logic       is_mult;
    logic       mem_read;
    logic       uses_rs2;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [9:0] expected;
  } vec_t;

  vec_t vecs[10];

  // EX_MEM holds a bubble while a multiply waits, so a redirect there is
  // a stimulus error rather than a design error.
  always begin
    @(negedge clk);
    #4;
    if (!rst) begin
      assert (!(mult_busy && !mult_start && exmem_take))
        else $error("[TB] exmem_take driven during multiply wait");
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    assert_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic clearInputs();
    id_rs1        = '0;
    id_rs2        = '0;
    id_uses_rs2   = 1'b0;
    idex_mem_read = 1'b0;
    idex_rd       = '0;
    idex_is_mult  = 1'b0;
    exmem_take    = 1'b0;
  endtask

  // Drives one vector for a single cycle in RUN, checks the decode, and
  // clears the inputs before the edge so the state stays RUN.
  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    exmem_take    = v.take;
    idex_is_mult  = v.is_mult;
    idex_mem_read = v.mem_read;
    id_uses_rs2   = v.uses_rs2;
    idex_rd       = v.rd;
    id_rs1        = v.rs1;
    id_rs2        = v.rs2;
    #2;
    checkOutput(v.name, 32'(outs), 32'(v.expected));
    #1;
    clearInputs();
  endtask

  task automatic doReset();
    @(negedge clk);
    rst    = 1'b1;
    enable = 1'b0;
    clearInputs();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Leaves the bench at a negedge with the controller already in RUN.
  task automatic startRun();
    @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
  endtask

  initial begin
    int starts;
    int busys;
    int frozen;

    vecs[0] = '{"nop",          0, 0, 0, 0, 5'd0, 5'd0, 5'd0, OUT_RUN};
    vecs[1] = '{"lu_rs1",       0, 0, 1, 0, 5'd5, 5'd5, 5'd0, OUT_LU};
    vecs[2] = '{"lu_rd_x0",     0, 0, 1, 0, 5'd0, 5'd0, 5'd0, OUT_RUN};
    vecs[3] = '{"lu_rs2_used",  0, 0, 1, 1, 5'd7, 5'd3, 5'd7, OUT_LU};
    vecs[4] = '{"lu_rs2_unused",0, 0, 1, 0, 5'd7, 5'd3, 5'd7, OUT_RUN};
    vecs[5] = '{"no_load",      0, 0, 0, 1, 5'd5, 5'd5, 5'd5, OUT_RUN};
    vecs[6] = '{"mult",         0, 1, 0, 0, 5'd0, 5'd0, 5'd0, OUT_MULT};
    vecs[7] = '{"mult_over_lu", 0, 1, 1, 0, 5'd9, 5'd9, 5'd0, OUT_MULT};
    vecs[8] = '{"take",         1, 0, 0, 0, 5'd0, 5'd0, 5'd0, OUT_REDIR};
    vecs[9] = '{"take_over_all",1, 1, 1, 1, 5'd4, 5'd4, 5'd4, OUT_REDIR};

    // Idle after reset, then a one-cycle enable pulse.
    doReset();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #2;
      checkOutput("idle_outs", 32'(outs), 32'(OUT_IDLE));
    end
    checkOutput("idle_stall_cnt", stall_cnt, 32'd0);
    checkOutput("idle_flush_cnt", flush_cnt, 32'd0);
    @(negedge clk);
    enable = 1'b1;
    #2;
    checkOutput("idle_with_enable", 32'(outs), 32'(OUT_IDLE));
    @(negedge clk);
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #2;
      checkOutput("run_pc_en", 32'(pc_en), 32'd1);
      @(negedge clk);
    end

    // Single-cycle decode table in RUN.
    for (int i = 0; i < 10; i++) applyStimulus(vecs[i]);

    // Load-use: one stall cycle, then the bubble clears the condition.
    doReset();
    startRun();
    idex_mem_read = 1'b1;
    idex_rd       = 5'd5;
    id_rs1        = 5'd5;
    #2;
    checkOutput("lu_stall_outs", 32'(outs), 32'(OUT_LU));
    @(negedge clk);
    clearInputs();
    #2;
    checkOutput("lu_resume_pc_en", 32'(pc_en), 32'd1);
    checkOutput("lu_stall_cnt", stall_cnt, 32'd1);
    idex_mem_read = 1'b1;
    idex_rd       = 5'd0;
    id_rs1        = 5'd0;
    #2;
    checkOutput("lu_x0_pc_en", 32'(pc_en), 32'd1);
    @(negedge clk);
    clearInputs();
    #2;
    checkOutput("lu_x0_stall_cnt", stall_cnt, 32'd1);

    // Four-cycle multiply; the MUL stays in ID_EX until release.
    doReset();
    startRun();
    idex_is_mult = 1'b1;
    starts = 0;
    busys  = 0;
    frozen = 0;
    for (int i = 0; i < 4; i++) begin
      #2;
      starts += int'(mult_start);
      busys  += int'(mult_busy);
      frozen += int'(!pc_en);
      if (i == 3) begin
        checkOutput("mult_release_ex_mem_en", 32'(ex_mem_en), 32'd1);
        checkOutput("mult_release_ex_mem_flush", 32'(ex_mem_flush), 32'd0);
      end
      @(negedge clk);
    end
    idex_is_mult = 1'b0;
    #2;
    checkOutput("mult_start_pulses", starts, 32'd1);
    checkOutput("mult_busy_cycles", busys, 32'd4);
    checkOutput("mult_frozen_cycles", frozen, 32'd3);
    checkOutput("mult_after_outs", 32'(outs), 32'(OUT_RUN));
    checkOutput("mult_stall_cnt", stall_cnt, 32'd3);

    // Redirect beats multiply and load-use in the same cycle.
    doReset();
    startRun();
    exmem_take    = 1'b1;
    idex_is_mult  = 1'b1;
    idex_mem_read = 1'b1;
    idex_rd       = 5'd6;
    id_rs1        = 5'd6;
    #2;
    checkOutput("redir_outs", 32'(outs), 32'(OUT_REDIR));
    @(negedge clk);
    clearInputs();
    #2;
    checkOutput("redir_flush_cnt", flush_cnt, 32'd1);
    checkOutput("redir_stall_cnt", stall_cnt, 32'd0);
    checkOutput("redir_stays_run", 32'(outs), 32'(OUT_RUN));

    // Reset during the second multiply-wait cycle.
    doReset();
    startRun();
    idex_is_mult = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #2;
    checkOutput("pre_reset_busy", 32'(mult_busy), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    idex_is_mult = 1'b0;
    #2;
    checkOutput("mid_mult_reset_outs", 32'(outs), 32'(OUT_IDLE));
    checkOutput("mid_mult_reset_stall_cnt", stall_cnt, 32'd0);
    checkOutput("mid_mult_reset_flush_cnt", flush_cnt, 32'd0);
    startRun();
    #2;
    checkOutput("rerun_outs", 32'(outs), 32'(OUT_RUN));
    @(negedge clk);
    #2;
    checkOutput("rerun_stall_cnt", stall_cnt, 32'd0);

    // Single-cycle multiplier: a MUL is an ordinary instruction.
    doReset();
    startRun();
    idex_is_mult = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #2;
      checkOutput("lat1_outs", 32'(outs_1), 32'(OUT_RUN));
      @(negedge clk);
    end
    idex_is_mult = 1'b0;
    #2;
    checkOutput("lat1_stall_cnt", stall_cnt_1, 32'd0);
    checkOutput("lat1_flush_cnt", flush_cnt_1, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
